// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART host-load path: controller
//               state encoding, memory-select and read/write flag constants,
//               and a saturating counter helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Controller states. 3 bits leave two spare codes; these are
  // recovered to ST_IDLE by the controller.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ_REQ = 3'd2,
    ST_READ_CAP = 3'd3,
    ST_TX_SEND  = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_e;

  // rx_mem_type / mem_sel encoding
  localparam logic MEM_IMEM = 1'b0;
  localparam logic MEM_DMEM = 1'b1;

  // rx_rw_flag encoding
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Index of the last byte of a 32-bit word sent over the transmitter
  localparam logic [1:0] TX_LAST_IDX = 2'd3;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_load_ctrl.sv
// ============================================================================
// Module      : uart_load_ctrl
// Description : Host memory-load controller. Takes decoded host packets
//               (rx_done + fields), performs a one-word write into the
//               instruction or data memory, or reads one word and returns it
//               over a byte transmitter, MSB byte first. The CPU is halted
//               whenever the controller owns the memories.
// Ports       : clk, reset        - clock, async active-high reset
//               rx_*              - received packet fields, qualified by rx_done
//               cpu_halt          - registered CPU stall
//               imem_we, dmem_we  - write strobes
//               mem_re, mem_sel   - read strobe and memory select
//               mem_addr/wdata    - registered address and write data
//               mem_rdata         - read data, one cycle after mem_re
//               tx_start/data     - byte transmitter handshake
//               tx_busy           - transmitter busy
//               overrun           - pulse: rx_done dropped while busy
//               wr_count          - saturating count of completed writes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_load_ctrl
  import uart_pkg::*;
#(
  parameter int          ADDR_W       = 9,
  parameter int          DATA_W       = 32,
  // Reset value of the write counter; non-zero only for preloading in test.
  parameter logic [15:0] WR_COUNT_RST = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic              rx_mem_type,
  input  logic              rx_rw_flag,
  output logic              cpu_halt,
  output logic              imem_we,
  output logic              dmem_we,
  output logic              mem_re,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              overrun,
  output logic [15:0]       wr_count
);

  state_e              state_q, state_d;
  logic                cap_q, cap_d;        // packet latched, dispatch pending
  logic                first_q, first_d;    // first TX_WAIT cycle after tx_start
  logic                rw_q;
  logic                mem_sel_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic                cpu_halt_q, cpu_halt_d;
  logic                overrun_q, overrun_d;

  logic                busy;
  logic                capture;
  logic                imem_we_c, dmem_we_c, mem_re_c, tx_start_c;

  // Busy covers the capture cycle as well: the packet is latched but the
  // FSM has not yet left IDLE, so a second rx_done there is also an overrun.
  assign busy    = cap_q || (state_q != ST_IDLE);
  assign capture = rx_done && !busy;

  // --------------------------------------------------------------------------
  // Next-state and strobe decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cap_d      = 1'b0;
    first_d    = 1'b0;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    wr_count_d = wr_count_q;
    imem_we_c  = 1'b0;
    dmem_we_c  = 1'b0;
    mem_re_c   = 1'b0;
    tx_start_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cap_q) begin
          state_d = (rw_q == RW_WRITE) ? ST_WRITE : ST_READ_REQ;
        end else if (rx_done) begin
          cap_d = 1'b1;
        end
      end

      ST_WRITE: begin
        imem_we_c  = (mem_sel_q == MEM_IMEM);
        dmem_we_c  = (mem_sel_q == MEM_DMEM);
        wr_count_d = sat_inc16(wr_count_q);
        state_d    = ST_IDLE;
      end

      ST_READ_REQ: begin
        mem_re_c = 1'b1;
        state_d  = ST_READ_CAP;
      end

      ST_READ_CAP: begin
        shreg_d    = mem_rdata;
        byte_cnt_d = 2'd0;
        state_d    = ST_TX_SEND;
      end

      ST_TX_SEND: begin
        if (!tx_busy) begin
          tx_start_c = 1'b1;
          first_d    = 1'b1;
          state_d    = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        // The transmitter may take a cycle to raise tx_busy, so the cycle
        // right after tx_start is not allowed to see "not busy".
        if (!first_q && !tx_busy) begin
          shreg_d    = shreg_q << 8;
          byte_cnt_d = byte_cnt_q + 2'd1;
          state_d    = (byte_cnt_q == TX_LAST_IDX) ? ST_IDLE : ST_TX_SEND;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_halt_d = cap_d || (state_d != ST_IDLE);
    overrun_d  = rx_done && busy;
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cap_q      <= 1'b0;
      first_q    <= 1'b0;
      shreg_q    <= '0;
      byte_cnt_q <= 2'd0;
      wr_count_q <= WR_COUNT_RST;
      cpu_halt_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      first_q    <= first_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      wr_count_q <= wr_count_d;
      cpu_halt_q <= cpu_halt_d;
      overrun_q  <= overrun_d;
    end
  end

  // Packet fields only change on an accepted rx_done; a dropped packet
  // leaves the in-flight operation untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q        <= RW_READ;
      mem_sel_q   <= MEM_IMEM;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (capture) begin
      rw_q        <= rx_rw_flag;
      mem_sel_q   <= rx_mem_type;
      mem_addr_q  <= rx_addr;
      mem_wdata_q <= rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cpu_halt  = cpu_halt_q;
  assign overrun   = overrun_q;
  assign wr_count  = wr_count_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign imem_we   = imem_we_c;
  assign dmem_we   = dmem_we_c;
  assign mem_re    = mem_re_c;
  assign tx_start  = tx_start_c;
  assign tx_data   = shreg_q[DATA_W-1 -: 8];

endmodule

`default_nettype wire

// File: tb/tb_uart_load_ctrl.sv
// ============================================================================
// Module      : tb_uart_load_ctrl
// Description : Scoreboard bench for uart_load_ctrl. Stimulus pushes expected
//               memory strobes, transmitted bytes and overrun pulses into
//               queues; a monitor pops and compares when the DUT presents
//               them. A second instance with a preloaded write counter
//               exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_load_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done = 1'b0;
  logic [31:0] rx_data = '0;
  logic [8:0]  rx_addr = '0;
  logic        rx_mem_type = 1'b0;
  logic        rx_rw_flag = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        model_busy = 1'b0;
  logic        ext_busy = 1'b0;
  logic        tx_busy;
  assign tx_busy = model_busy | ext_busy;

  logic        cpu_halt, imem_we, dmem_we, mem_re, mem_sel, tx_start, overrun;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  tx_data;
  logic [15:0] wr_count;

  logic        s_cpu_halt, s_imem_we, s_dmem_we, s_mem_re, s_mem_sel, s_tx_start, s_overrun;
  logic [8:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [7:0]  s_tx_data;
  logic [15:0] s_wr_count;

  uart_load_ctrl dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_addr(rx_addr),
    .rx_mem_type(rx_mem_type), .rx_rw_flag(rx_rw_flag), .cpu_halt(cpu_halt),
    .imem_we(imem_we), .dmem_we(dmem_we), .mem_re(mem_re), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .overrun(overrun),
    .wr_count(wr_count)
  );

  uart_load_ctrl #(.WR_COUNT_RST(16'hFFFE)) dut_sat (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_addr(rx_addr),
    .rx_mem_type(rx_mem_type), .rx_rw_flag(rx_rw_flag), .cpu_halt(s_cpu_halt),
    .imem_we(s_imem_we), .dmem_we(s_dmem_we), .mem_re(s_mem_re), .mem_sel(s_mem_sel),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .tx_start(s_tx_start), .tx_data(s_tx_data), .tx_busy(tx_busy), .overrun(s_overrun),
    .wr_count(s_wr_count)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  port;   // {imem_we, dmem_we}
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [8:0] exp_re[$];
  logic [7:0] exp_tx[$];
  int         ovr_pending = 0;
  int         tx_seen = 0;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] rd_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge clk) begin
    if (imem_we || dmem_we || mem_re || tx_start)
      chk("strobe_onehot", 32'($countones({imem_we, dmem_we, mem_re, tx_start})), 32'd1);

    if (imem_we || dmem_we) begin
      if (exp_wr.size() == 0) unexpected("write_strobe");
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_port", {30'd0, imem_we, dmem_we}, {30'd0, e.port});
        chk("wr_addr", {23'd0, mem_addr}, {23'd0, e.addr});
        chk("wr_data", mem_wdata, e.data);
      end
    end

    if (mem_re) begin
      if (exp_re.size() == 0) unexpected("read_strobe");
      else begin
        logic [8:0] a;
        a = exp_re.pop_front();
        chk("re_addr", {23'd0, mem_addr}, {23'd0, a});
        chk("re_sel", {31'd0, mem_sel}, {31'd0, MEM_DMEM});
      end
    end

    if (tx_start) begin
      tx_seen++;
      if (exp_tx.size() == 0) unexpected("tx_start");
      else begin
        logic [7:0] b;
        b = exp_tx.pop_front();
        chk("tx_byte", {24'd0, tx_data}, {24'd0, b});
      end
    end

    if (overrun) begin
      if (ovr_pending == 0) unexpected("overrun");
      else begin
        ovr_pending--;
        chk("overrun", {31'd0, overrun}, 32'd1);
      end
    end
  end

  // Byte transmitter model: busy from the cycle after tx_start for 3 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        logic [7:0] sent;
        sent = tx_data;
        @(posedge clk); #1;
        model_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (cpu_halt && !reset) chk("tx_data_stable", {24'd0, tx_data}, {24'd0, sent});
        model_busy = 1'b0;
      end
    end
  end

  // Memory read model: data valid for the cycle after mem_re.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_re === 1'b1) begin
        @(posedge clk); #1;
        mem_rdata = rd_word;
        @(posedge clk); #1;
        mem_rdata = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send(input logic rw, input logic typ, input logic [8:0] addr,
                      input logic [31:0] data);
    @(posedge clk); #1;
    rx_rw_flag  = rw;
    rx_mem_type = typ;
    rx_addr     = addr;
    rx_data     = data;
    rx_done     = 1'b1;
    @(posedge clk); #1;
    rx_done     = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_tx.push_back(w[31:24]);
    exp_tx.push_back(w[23:16]);
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!cpu_halt && exp_tx.size() == 0 && !model_busy) break;
    end
    chk(name, {31'd0, cpu_halt}, 32'd0);
    chk("queues_drained", 32'(exp_tx.size() + exp_wr.size() + exp_re.size() + ovr_pending), 32'd0);
  endtask

  // Returns just after the posedge that follows the target tx_start.
  task automatic wait_tx(input int target);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (tx_seen >= target) break;
    end
    chk("tx_reached", {31'd0, (tx_seen >= target)}, 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int halt_n, we_n, base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halt", {31'd0, cpu_halt}, 32'd0);
    chk("rst_strobes", {28'd0, imem_we, dmem_we, mem_re, tx_start}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("rst_sat_count", {16'd0, s_wr_count}, 32'h0000_FFFE);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    reset = 1'b0;

    // imem write
    exp_wr.push_back('{port: 2'b10, addr: 9'h005, data: 32'hDEADBEEF});
    send(RW_WRITE, MEM_IMEM, 9'h005, 32'hDEADBEEF);
    halt_n = 0; we_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      halt_n += int'(cpu_halt);
      we_n   += int'(imem_we);
    end
    chk("wr_halt_cycles", 32'(halt_n), 32'd2);
    chk("wr_we_cycles", 32'(we_n), 32'd1);
    chk("wr_count_1", {16'd0, wr_count}, 32'd1);

    // dmem read, mem_re two cycles after rx_done
    rd_word = 32'h12345678;
    exp_re.push_back(9'h010);
    push_word(32'h12345678);
    send(RW_READ, MEM_DMEM, 9'h010, 32'h0);
    @(negedge clk);
    chk("re_not_early", {31'd0, mem_re}, 32'd0);
    @(negedge clk);
    chk("re_timing", {31'd0, mem_re}, 32'd1);
    wait_idle("read_idle");

    // overrun during TX_WAIT
    rd_word = 32'hA1B2C3D4;
    exp_re.push_back(9'h020);
    push_word(32'hA1B2C3D4);
    send(RW_READ, MEM_DMEM, 9'h020, 32'h0);
    base = tx_seen;
    wait_tx(base + 1);
    rx_rw_flag = RW_WRITE; rx_mem_type = MEM_IMEM;
    rx_addr = 9'h1FF; rx_data = 32'hFFFFFFFF;
    rx_done = 1'b1;
    ovr_pending++;
    @(posedge clk); #1;
    rx_done = 1'b0;
    @(negedge clk);
    chk("ovr_addr_kept", {23'd0, mem_addr}, 32'h020);
    chk("ovr_sel_kept", {31'd0, mem_sel}, 32'd1);
    wait_idle("ovr_idle");
    chk("ovr_wr_count", {16'd0, wr_count}, 32'd1);

    // transmitter busy on entry to TX_SEND
    ext_busy = 1'b1;
    rd_word = 32'h0BADF00D;
    exp_re.push_back(9'h033);
    base = tx_seen;
    send(RW_READ, MEM_DMEM, 9'h033, 32'h0);
    repeat (24) @(negedge clk);
    chk("busy_no_start", 32'(tx_seen - base), 32'd0);
    chk("busy_halted", {31'd0, cpu_halt}, 32'd1);
    push_word(32'h0BADF00D);
    @(posedge clk); #1;
    ext_busy = 1'b0;
    wait_idle("busy_idle");

    // reset after the second byte
    rd_word = 32'hCAFEF00D;
    exp_re.push_back(9'h044);
    exp_tx.push_back(8'hCA);
    exp_tx.push_back(8'hFE);
    base = tx_seen;
    send(RW_READ, MEM_DMEM, 9'h044, 32'h0);
    wait_tx(base + 2);
    #1 reset = 1'b1;
    #1;
    chk("mrst_halt", {31'd0, cpu_halt}, 32'd0);
    chk("mrst_strobes", {27'd0, imem_we, dmem_we, mem_re, tx_start, overrun}, 32'd0);
    chk("mrst_addr", {23'd0, mem_addr}, 32'd0);
    chk("mrst_sel", {31'd0, mem_sel}, 32'd0);
    chk("mrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mrst_wr_count", {16'd0, wr_count}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("mrst_no_more_tx", 32'(tx_seen - base), 32'd2);
    exp_wr.push_back('{port: 2'b01, addr: 9'h07F, data: 32'h00001234});
    send(RW_WRITE, MEM_DMEM, 9'h07F, 32'h00001234);
    repeat (4) @(negedge clk);
    chk("mrst_write_count", {16'd0, wr_count}, 32'd1);

    // saturation with a counter preloaded to 0xFFFE
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("sat_preload", {16'd0, s_wr_count}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      exp_wr.push_back('{port: 2'b10, addr: 9'(i + 1), data: 32'(i + 100)});
      send(RW_WRITE, MEM_IMEM, 9'(i + 1), 32'(i + 100));
      repeat (3) @(negedge clk);
      chk("sat_main_count", {16'd0, wr_count}, 32'(i + 1));
      chk("sat_count", {16'd0, s_wr_count}, 32'h0000_FFFF);
    end

    repeat (5) @(negedge clk);
    chk("final_drained", 32'(exp_tx.size() + exp_wr.size() + exp_re.size() + ovr_pending), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/uart_load_ctrl.md
UART_LOAD_CTRL -- requirements
Module: uart_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, memory word address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width; fixed at 4 bytes.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_done, input, 1, one-cycle pulse: host packet fully received.
REQ-006 SHALL have port rx_data, input, 32, write payload, valid with rx_done.
REQ-007 SHALL have port rx_addr, input, 9, target word address, valid with rx_done.
REQ-008 SHALL have port rx_mem_type, input, 1, target memory: 0 = instruction, 1 = data.
REQ-009 SHALL have port rx_rw_flag, input, 1, operation: 1 = write, 0 = read.
REQ-010 SHALL have port cpu_halt, output, 1, stalls the CPU pipeline while the controller is busy.
REQ-011 SHALL have port imem_we / dmem_we, output, 1 each, write strobes.
REQ-012 SHALL have port mem_re, output, 1, read strobe to the memory selected by mem_sel.
REQ-013 SHALL have port mem_sel, output, 1, registered copy of rx_mem_type.
REQ-014 SHALL have port mem_addr, output, 9, registered word address.
REQ-015 SHALL have port mem_wdata, output, 32, registered write data.
REQ-016 SHALL have port mem_rdata, input, 32, read data, valid exactly 1 cycle after mem_re.
REQ-017 SHALL have port tx_start, output, 1, one-cycle start pulse to the byte transmitter.
REQ-018 SHALL have port tx_data, output, 8, byte to send, stable from tx_start until tx_busy falls.
REQ-019 SHALL have port tx_busy, input, 1, transmitter busy; high no later than 1 cycle after tx_start.
REQ-020 SHALL have port overrun, output, 1, one-cycle pulse when rx_done is dropped because the controller is busy.
REQ-021 SHALL have port wr_count, output, 16, count of completed writes; saturates at 0xFFFF.

Function
REQ-022 SHALL implement the states IDLE, WRITE, READ_REQ, READ_CAP, TX_SEND, TX_WAIT.
REQ-023 SHALL latch rx_addr, rx_data, rx_mem_type and rx_rw_flag when in IDLE with rx_done=1.
REQ-024 SHALL on that capture go to WRITE if rx_rw_flag=1, else to READ_REQ.
REQ-025 SHALL in WRITE assert imem_we (mem_sel=0) or dmem_we (mem_sel=1) for exactly 1 cycle, increment wr_count, then return to IDLE.
REQ-026 SHALL in READ_REQ assert mem_re for 1 cycle, then go to READ_CAP.
REQ-027 SHALL in READ_CAP capture mem_rdata into a 32-bit shift register, clear the byte counter, then go to TX_SEND.
REQ-028 SHALL in TX_SEND pulse tx_start for 1 cycle with tx_data = shift register [31:24] when tx_busy=0; while tx_busy=1 it SHALL stay in TX_SEND without pulsing.
REQ-029 SHALL in TX_WAIT ignore tx_busy for the first cycle after tx_start, then wait for tx_busy=0.
REQ-030 SHALL on leaving TX_WAIT shift the register left by 8 bits and increment the byte counter; at count 3 it SHALL go to IDLE, else to TX_SEND.
REQ-031 SHALL transmit the read word MSB byte first, 4 bytes total.
REQ-032 SHALL drive cpu_halt = 1 in every state except IDLE; cpu_halt SHALL be registered (glitch-free).
REQ-033 SHALL in IDLE assert cpu_halt in the same cycle as the capture edge, i.e. the cycle after rx_done.
REQ-034 SHALL ignore rx_done when the state is not IDLE and pulse overrun the next cycle; registered state SHALL be unaffected.
REQ-035 SHALL keep we/re/tx_start low in all states other than the one that owns them.
REQ-036 SHALL treat any illegal state encoding as IDLE on the next clock.
REQ-037 SHALL complete a write in 2 cycles from rx_done (capture, WRITE) and issue the read mem_re 2 cycles after rx_done.

Reset
REQ-038 SHALL on reset assertion immediately force IDLE, zero all outputs, wr_count, byte counter and shift register; this includes mid-transmit, with no further tx_start.
REQ-039 SHALL resume normal operation on the first clock edge after reset deasserts.

Structure
REQ-040 SHALL take the state encoding, the MEM_IMEM/MEM_DMEM constants and the RW_WRITE/RW_READ constants from the shared package uart_pkg.
REQ-041 SHALL be a single module with no sub-modules; the transmitter is instantiated at the top level, not inside this block.

Verification
REQ-042 SHALL cover imem write: rx_done with rw=1, type=0, addr=0x005, data=0xDEADBEEF -> imem_we 1 cycle, addr 0x005, wdata 0xDEADBEEF, wr_count=1, cpu_halt high for 2 cycles.
REQ-043 SHALL cover dmem read: rw=0, type=1, addr=0x010, mem_rdata=0x12345678 -> tx bytes 0x12, 0x34, 0x56, 0x78 in order, then IDLE with cpu_halt low.
REQ-044 SHALL cover overrun: rx_done during TX_WAIT -> overrun pulse, transmission unchanged, no memory strobe.
REQ-045 SHALL cover a busy transmitter: tx_busy held high 20 cycles on entering TX_SEND -> no tx_start until tx_busy falls.
REQ-046 SHALL cover reset after the 2nd transmitted byte -> all outputs 0 immediately, no further tx_start, and a subsequent write works.
REQ-047 SHALL cover saturation: wr_count preloaded to 0xFFFE, then 3 writes -> wr_count = 0xFFFF.
